// File: rtl/ucc_meta_if.sv
// MCU data-bus snoop bundle shared by the bus model (master) and the META loader (slave).
interface ucc_meta_if;
  logic        data_en;
  logic        data_wr;
  logic [15:0] data_addr;
  logic [15:0] data_wdata;

  modport master (output data_en, data_wr, data_addr, data_wdata);
  modport slave  (input  data_en, data_wr, data_addr, data_wdata);
endinterface

// File: rtl/ucc_meta_loader.sv
// Snoops META-window writes, validates the UCC region table one region per cycle and locks it.
// Optional macro UCC_OVERLAP_CHECK_EN adds a strictly-ascending, non-overlapping region check.
module ucc_meta_loader #(
  parameter int          N_UCC        = 10,
  parameter logic [15:0] META_MIN     = 16'h0140,
  parameter logic [15:0] META_MAX     = 16'h016A,
  parameter logic [7:0]  COMMIT_MAGIC = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ucc_meta_if.slave              bus,
  output logic [16*N_UCC-1:0]    ucc_min,
  output logic [16*N_UCC-1:0]    ucc_max,
  output logic [N_UCC-1:0]       ucc_valid,
  output logic                   locked,
  output logic                   busy,
  output logic                   meta_violation
);

  typedef enum logic [1:0] {COLLECT, VALIDATE, LOCKED, FAULT} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [7:0]  idx_reg, idx_next;

  logic        meta_wr;
  logic [15:0] offset;
  logic [14:0] word;
  logic [14:0] word_m1;
  logic [13:0] slot;
  logic        is_min;
  logic        shadow_we;
  logic        commit;

  logic [15:0] cur_min, cur_max, prev_max;
  logic        region_bad;
  logic [N_UCC-1:0] valid_mask;

  // Word 0 wraps word_m1 to all-ones, so it never aliases a slot; word 21 maps past the last slot.
  assign meta_wr   = bus.data_en & bus.data_wr &
                     (bus.data_addr >= META_MIN) & (bus.data_addr <= META_MAX);
  assign offset    = bus.data_addr - META_MIN;
  assign word      = offset[15:1];
  assign word_m1   = word - 15'd1;
  assign slot      = word_m1[14:1];
  assign is_min    = ~word_m1[0];
  assign shadow_we = meta_wr & (state_reg == COLLECT) & (slot < 14'(N_UCC));
  assign commit    = meta_wr & (word == 15'd0) & (bus.data_wdata[15:8] == COMMIT_MAGIC);

  for (genvar gi = 0; gi < N_UCC; gi++) begin : g_mask
    assign valid_mask[gi] = (cnt_next > 8'(gi));
  end

  always_comb begin
    cur_min  = '0;
    cur_max  = '0;
    prev_max = '0;
    for (int i = 0; i < N_UCC; i++) begin
      if (idx_reg == 8'(i)) begin
        cur_min = ucc_min[16*i +: 16];
        cur_max = ucc_max[16*i +: 16];
      end
      if (idx_reg == 8'(i + 1)) begin
        prev_max = ucc_max[16*i +: 16];
      end
    end
    region_bad = (cur_min > cur_max) | cur_min[0] | cur_max[0];
`ifdef UCC_OVERLAP_CHECK_EN
    if ((idx_reg != 8'd0) && (cur_min <= prev_max)) begin
      region_bad = 1'b1;
    end
`else
    if (prev_max == 16'hFFFF && 1'b0) begin
      region_bad = 1'b1;
    end
`endif
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    case (state_reg)
      COLLECT: begin
        if (commit) begin
          cnt_next   = bus.data_wdata[7:0];
          idx_next   = 8'd0;
          // An empty table has nothing to check and locks on the next edge.
          state_next = (bus.data_wdata[7:0] == 8'd0) ? LOCKED : VALIDATE;
        end
      end
      VALIDATE: begin
        if (meta_wr) begin
          state_next = FAULT;
        end else if (cnt_reg > 8'(N_UCC)) begin
          state_next = FAULT;
        end else if (cnt_reg == 8'd0) begin
          state_next = LOCKED;
        end else if (region_bad) begin
          state_next = FAULT;
        end else if (idx_reg + 8'd1 == cnt_reg) begin
          state_next = LOCKED;
        end else begin
          idx_next = idx_reg + 8'd1;
        end
      end
      LOCKED: begin
        if (meta_wr) begin
          state_next = FAULT;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= COLLECT;
      cnt_reg        <= 8'd0;
      idx_reg        <= 8'd0;
      busy           <= 1'b0;
      locked         <= 1'b0;
      meta_violation <= 1'b0;
      ucc_valid      <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      busy           <= (state_next == VALIDATE);
      locked         <= (state_next == LOCKED);
      meta_violation <= (state_next == FAULT);
      ucc_valid      <= (state_next == LOCKED) ? valid_mask : '0;
    end
  end

  // Shadow bounds double as the ucc_min/ucc_max outputs; they only move while collecting.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ucc_min <= '0;
      ucc_max <= '0;
    end else if (shadow_we) begin
      for (int i = 0; i < N_UCC; i++) begin
        if (slot == 14'(i)) begin
          if (is_min) begin
            ucc_min[16*i +: 16] <= bus.data_wdata;
          end else begin
            ucc_max[16*i +: 16] <= bus.data_wdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ucc_meta_loader.sv
// Directed bench for ucc_meta_loader: table load, commit timing, fault paths and reset.
module tb_ucc_meta_loader;
  localparam int N_UCC = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [16*N_UCC-1:0] ucc_min, ucc_max;
  logic [N_UCC-1:0]    ucc_valid;
  logic locked, busy, meta_violation;
  int checks = 0;
  int errors = 0;

  ucc_meta_if bus ();

  ucc_meta_loader #(.N_UCC(N_UCC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .ucc_min(ucc_min), .ucc_max(ucc_max), .ucc_valid(ucc_valid),
    .locked(locked), .busy(busy), .meta_violation(meta_violation)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Returns just after the sampling edge, i.e. in cycle T+1 of the write.
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.data_en = 1'b1; bus.data_wr = 1'b1; bus.data_addr = a; bus.data_wdata = d;
    @(posedge clk); #1;
    bus.data_en = 1'b0; bus.data_wr = 1'b0;
    $display("write [%h] <= %h", a, d);
  endtask

  task automatic bus_read(input logic [15:0] a);
    @(negedge clk);
    bus.data_en = 1'b1; bus.data_wr = 1'b0; bus.data_addr = a; bus.data_wdata = 16'hFFFF;
    @(posedge clk); #1;
    bus.data_en = 1'b0;
    $display("read  [%h]", a);
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;
  endtask

  initial begin
    bus.data_en = 1'b0; bus.data_wr = 1'b0; bus.data_addr = 16'h0; bus.data_wdata = 16'h0;
    do_reset();
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_viol", {31'd0, meta_violation}, 32'd0);
    check("rst_valid", {22'd0, ucc_valid}, 32'd0);
    check("rst_min0", {16'd0, ucc_min[15:0]}, 32'd0);

    // Two-region table, commit count 2
    bus_write(16'h0142, 16'hE000);
    check("min0_visible", {16'd0, ucc_min[15:0]}, 32'h0000E000);
    bus_write(16'h0144, 16'hE0FE);
    bus_write(16'h0146, 16'hE200);
    bus_write(16'h0148, 16'hE2FE);
    check("min1_loaded", {16'd0, ucc_min[31:16]}, 32'h0000E200);
    bus_write(16'h0140, 16'hA502);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_locked", {31'd0, locked}, 32'd0);
    step();
    check("t2_busy", {31'd0, busy}, 32'd1);
    step();
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_locked", {31'd0, locked}, 32'd1);
    check("t3_valid", {22'd0, ucc_valid}, 32'h3);
    check("t3_min1", {16'd0, ucc_min[31:16]}, 32'h0000E200);
    bus_read(16'h0142);
    check("read_no_viol", {31'd0, meta_violation}, 32'd0);
    bus_write(16'h0142, 16'h1234);
    check("lock_wr_viol", {31'd0, meta_violation}, 32'd1);
    check("lock_wr_valid", {22'd0, ucc_valid}, 32'd0);
    check("lock_wr_locked", {31'd0, locked}, 32'd0);
    check("lock_wr_min0", {16'd0, ucc_min[15:0]}, 32'h0000E000);

    // min > max fails on first region
    do_reset();
    check("rst2_min0", {16'd0, ucc_min[15:0]}, 32'd0);
    bus_write(16'h0142, 16'hF000);
    bus_write(16'h0144, 16'hE000);
    bus_write(16'h0140, 16'hA501);
    check("bad_t1_viol", {31'd0, meta_violation}, 32'd0);
    step();
    check("bad_t2_viol", {31'd0, meta_violation}, 32'd1);
    check("bad_t2_locked", {31'd0, locked}, 32'd0);

    // Odd bound fails
    do_reset();
    bus_write(16'h0142, 16'hE001);
    bus_write(16'h0144, 16'hE0FE);
    bus_write(16'h0140, 16'hA501);
    step();
    check("odd_viol", {31'd0, meta_violation}, 32'd1);

    // Count above N_UCC
    do_reset();
    bus_write(16'h0140, 16'hA50B);
    check("cnt11_t1_busy", {31'd0, busy}, 32'd1);
    step();
    check("cnt11_t2_viol", {31'd0, meta_violation}, 32'd1);

    // Count zero locks immediately
    do_reset();
    bus_write(16'h0140, 16'hA500);
    check("cnt0_locked", {31'd0, locked}, 32'd1);
    check("cnt0_busy", {31'd0, busy}, 32'd0);
    check("cnt0_valid", {22'd0, ucc_valid}, 32'd0);

    // Wrong magic ignored; last slot, reserved word, and address bit 0
    do_reset();
    bus_write(16'h0140, 16'h5A02);
    check("badmagic_busy", {31'd0, busy}, 32'd0);
    check("badmagic_locked", {31'd0, locked}, 32'd0);
    bus_write(16'h0143, 16'h1110);
    check("collect_odd_addr", {16'd0, ucc_min[15:0]}, 32'h00001110);
    bus_write(16'h0166, 16'hC000);
    bus_write(16'h0168, 16'hC0FE);
    bus_write(16'h016A, 16'hFFFF);
    check("slot9_min", {16'd0, ucc_min[159:144]}, 32'h0000C000);
    check("slot9_max", {16'd0, ucc_max[159:144]}, 32'h0000C0FE);
    check("reserved_viol", {31'd0, meta_violation}, 32'd0);

    // META write while validating
    do_reset();
    bus_write(16'h0142, 16'hE000);
    bus_write(16'h0144, 16'hE0FE);
    bus_write(16'h0140, 16'hA503);
    bus_write(16'h0150, 16'h0000);
    check("val_wr_viol", {31'd0, meta_violation}, 32'd1);
    check("val_wr_busy", {31'd0, busy}, 32'd0);

    // Reset mid-validate
    do_reset();
    bus_write(16'h0142, 16'hE000);
    bus_write(16'h0144, 16'hE0FE);
    bus_write(16'h0140, 16'hA503);
    check("midval_busy", {31'd0, busy}, 32'd1);
    do_reset();
    check("midval_rst_busy", {31'd0, busy}, 32'd0);
    check("midval_rst_viol", {31'd0, meta_violation}, 32'd0);
    check("midval_rst_min0", {16'd0, ucc_min[15:0]}, 32'd0);
    check("midval_rst_max0", {16'd0, ucc_max[15:0]}, 32'd0);

    // Overlapping regions
    do_reset();
    bus_write(16'h0142, 16'hE000);
    bus_write(16'h0144, 16'hE1FE);
    bus_write(16'h0146, 16'hE100);
    bus_write(16'h0148, 16'hE2FE);
    bus_write(16'h0140, 16'hA502);
    step();
    step();
`ifdef UCC_OVERLAP_CHECK_EN
    check("overlap_viol", {31'd0, meta_violation}, 32'd1);
    check("overlap_locked", {31'd0, locked}, 32'd0);
`else
    check("overlap_locked", {31'd0, locked}, 32'd1);
    check("overlap_valid", {22'd0, ucc_valid}, 32'h3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ucc_meta_loader.md
# ucc_meta_loader

Loads the untrusted-code-compartment (UCC) region table that software writes into the META window (0x0140–0x016A), validates it, and drives the per-region `min`/`max` definition wires that the hardware monitor consumes. It snoops MCU data-bus writes, so no extra bus slave port is needed. It validates the table one region per cycle and then locks it. While the table is locked, or after validation fails, any further write to META raises a sticky violation that the monitor ORs into its master reset.

## Interface
Parameters:
- `N_UCC`, 10: number of region slots (max 10; the META window holds 1 control word plus 10 min/max pairs).
- `META_MIN`, 16'h0140: base of the META window, inclusive.
- `META_MAX`, 16'h016A: top of the META window, inclusive.
- `COMMIT_MAGIC`, 8'hA5: control-word upper byte that triggers validation.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, **synchronous, active-low**.
- `data_en` in 1: data-bus access strobe.
- `data_wr` in 1: access is a write.
- `data_addr` in 16: byte address.
- `data_wdata` in 16: write data, valid in the same cycle as `data_en & data_wr`.
- `ucc_min` out 16*N_UCC: region i lower bound at bits [16i+15:16i].
- `ucc_max` out 16*N_UCC: region i upper bound, same packing.
- `ucc_valid` out N_UCC: region i is active.
- `locked` out 1: table committed and frozen.
- `busy` out 1: validation in progress.
- `meta_violation` out 1: sticky reset request to the monitor.

## Operation
- Write decode: `wr = data_en & data_wr & (META_MIN <= data_addr <= META_MAX)`. The word index is `(data_addr - META_MIN) >> 1`, so bit 0 is ignored.
- Word map:
  - Word 0 is the control word: [7:0] = count, [15:8] = magic.
  - Word 1+2i is `min[i]`.
  - Word 2+2i is `max[i]`.
  - Word 21 (0x016A) is reserved.
- **COLLECT** (reset state):
  - A write to a min/max word with i < N_UCC stores `data_wdata` into the shadow register.
  - Writes to i ≥ N_UCC or to the reserved word are ignored.
  - A control write with magic ≠ `COMMIT_MAGIC` is ignored.
  - A control write with magic = `COMMIT_MAGIC` latches `cnt = data_wdata[7:0]`, clears `idx`, and moves to VALIDATE.
- **VALIDATE**, one region per cycle:
  - If `cnt > N_UCC`, go to FAULT on the first VALIDATE cycle.
  - If `cnt == 0`, go straight to LOCKED with `ucc_valid = 0`.
  - Otherwise check region `idx`: it fails if `min[idx] > max[idx]` or either bound is odd.
  - On failure go to FAULT. Otherwise increment `idx`. After region `cnt-1` passes, go to LOCKED.
  - Any META write during VALIDATE goes to FAULT.
- **LOCKED**:
  - `ucc_valid[i] = (i < cnt)`. Shadow registers are frozen.
  - Any META write, including to the reserved word, sets `meta_violation` and moves to FAULT.
- **FAULT**:
  - `meta_violation = 1` and `ucc_valid = 0`.
  - The only exit is `reset_n` low.
- `ucc_min`/`ucc_max` always reflect the shadow registers. Consumers gate them with `ucc_valid`.

## Timing
- Reset values (`reset_n` low at a `clk` rising edge):
  - state = COLLECT.
  - All shadow registers = 16'h0000.
  - `cnt` = 0, `idx` = 0.
  - `ucc_valid` = 0, `locked` = 0, `busy` = 0, `meta_violation` = 0.
- A shadow write is visible on `ucc_min`/`ucc_max` in the cycle after the bus write.
- Commit write in cycle T:
  - `busy` = 1 from T+1 through T+cnt.
  - `locked` = 1 and `ucc_valid` updated at T+cnt+1.
  - With `cnt == 0`, `locked` = 1 at T+1.
- A failure detected in VALIDATE cycle k sets `meta_violation` = 1 in the next cycle.
- A META write while LOCKED sets `meta_violation` = 1 in the cycle after the write.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset asserted mid-VALIDATE, or in any state, returns the block to the full reset values at the next edge.
- Simultaneous commit and reset: reset wins.

## Configuration
- `UCC_OVERLAP_CHECK_EN` defined: VALIDATE additionally fails region `idx` > 0 if `min[idx] <= max[idx-1]`. Regions must be strictly ascending and non-overlapping. The check adds no extra cycles.
- `UCC_OVERLAP_CHECK_EN` undefined: no inter-region check. Overlapping or unordered regions are accepted.

## Test plan
- Region 0 = 0xE000/0xE0FE, region 1 = 0xE200/0xE2FE, then control write 0xA502:
  - `busy` high for 2 cycles.
  - `locked` = 1 and `ucc_valid` = 2'b11 at T+3.
  - `ucc_min[31:16]` = 0xE200.
- After lock, write 0x1234 to 0x0142 → `meta_violation` = 1 the next cycle and `ucc_valid` = 0; `min[0]` stays 0xE000.
- Region 0 = 0xF000/0xE000, then commit 0xA501 → FAULT with `meta_violation` = 1 at T+2 and `locked` = 0.
- Commit 0xA50B (count 11 > N_UCC) → FAULT; commit 0xA500 → `locked` = 1 at T+1 with `ucc_valid` = 0.
- Control write 0x5A02 → ignored, state stays COLLECT; META write during VALIDATE → FAULT; pull `reset_n` low mid-VALIDATE → all outputs return to reset values next cycle.
- With `UCC_OVERLAP_CHECK_EN`: regions 0xE000/0xE1FE and 0xE100/0xE2FE, commit 0xA502 → FAULT. The same table without the macro → `locked` = 1.
